// File: rtl/tx_frame_packer.sv
// tx_frame_packer: packs each contiguous tx_en run into a frame with a trailing XOR checksum byte.
// Latency: first-word fall-through; a frame becomes readable right after the edge that writes its checksum.
// Backpressure: a valid/ready read side; a frame that runs out of space or exceeds MAX_LEN is dropped whole.
module tx_frame_packer #(
   parameter int DEPTH   = 16,
   parameter int MAX_LEN = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_txd,
   input  logic       i_tx_en,
   output logic [7:0] o_dout,
   output logic       o_dout_valid,
   input  logic       i_dout_ready,
   output logic       o_dout_last,
   output logic       o_frame_drop,
   output logic [7:0] o_frame_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(MAX_LEN + 1);
   // Writing a byte is allowed only while at least two slots are free,
   // so the checksum of an accepted frame always has a slot waiting.
   localparam logic [AW:0]   C_USED_MAX = (AW + 1)'(DEPTH - 2);
   localparam logic [LW-1:0] C_MAX_LEN  = LW'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD} state_t;

   state_t      r_state;
   logic [AW:0] r_wr_ptr;     // speculative: includes the frame being collected
   logic [AW:0] r_cm_ptr;     // committed: end of the last complete frame
   logic [AW:0] r_rd_ptr;
   logic [7:0]  r_chk;
   logic [LW-1:0] r_len;
   logic        r_frame_drop;
   logic [7:0]  r_frame_cnt;
   // Each entry is {data, last}
   logic [8:0]  r_mem [DEPTH];

   logic [AW:0] w_used;
   logic        w_room;
   logic        w_wr_en;
   logic [8:0]  w_wr_dat;
   logic        w_rd_en;

   assign w_used  = r_wr_ptr - r_rd_ptr;
   assign w_room  = (w_used <= C_USED_MAX);
   assign w_rd_en = o_dout_valid & i_dout_ready;

   // Decode which entry (payload byte or checksum) is written this cycle
   always_comb begin
      w_wr_en  = 1'b0;
      w_wr_dat = {i_txd, 1'b0};
      case (r_state)
         S_IDLE: w_wr_en = i_tx_en & w_room;
         S_COLLECT: begin
            if (i_tx_en) begin
               w_wr_en = (r_len != C_MAX_LEN) & w_room;
            end else begin
               w_wr_en  = 1'b1;
               w_wr_dat = {r_chk, 1'b1};
            end
         end
         default: w_wr_en = 1'b0;
      endcase
   end

   // Storage array, deliberately not reset
   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_dat;
   end

   // Input FSM: collect, commit on frame end, roll back on drop
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_cm_ptr     <= '0;
         r_chk        <= '0;
         r_len        <= '0;
         r_frame_drop <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_frame_drop <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_tx_en) begin
                  if (w_room) begin
                     r_wr_ptr <= r_wr_ptr + 1'b1;
                     r_chk    <= i_txd;
                     r_len    <= LW'(1);
                     r_state  <= S_COLLECT;
                  end else begin
                     r_frame_drop <= 1'b1;
                     r_state      <= S_DISCARD;
                  end
               end
            end
            S_COLLECT: begin
               if (i_tx_en) begin
                  if ((r_len == C_MAX_LEN) || !w_room) begin
                     r_wr_ptr     <= r_cm_ptr;
                     r_frame_drop <= 1'b1;
                     r_len        <= '0;
                     r_state      <= S_DISCARD;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + 1'b1;
                     r_chk    <= r_chk ^ i_txd;
                     r_len    <= r_len + 1'b1;
                  end
               end else begin
                  r_wr_ptr    <= r_wr_ptr + 1'b1;
                  r_cm_ptr    <= r_wr_ptr + 1'b1;
                  r_frame_cnt <= r_frame_cnt + 1'b1;
                  r_len       <= '0;
                  r_state     <= S_IDLE;
               end
            end
            S_DISCARD: begin
               if (!i_tx_en) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read pointer advances on each accepted output byte
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_rd_ptr <= '0;
      else if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
   end

   assign o_dout_valid = (r_rd_ptr != r_cm_ptr);
   assign o_dout       = o_dout_valid ? r_mem[r_rd_ptr[AW-1:0]][8:1] : 8'd0;
   assign o_dout_last  = o_dout_valid ? r_mem[r_rd_ptr[AW-1:0]][0] : 1'b0;
   assign o_frame_drop = r_frame_drop;
   assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_tx_frame_packer.sv
// Bench for tx_frame_packer: directed scenarios plus random frames and random
// backpressure, checked every cycle against a queue-based frame model.
module tb_tx_frame_packer;

   localparam int DEPTH   = 16;
   localparam int MAX_LEN = 8;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [7:0] i_txd = 8'd0;
   logic       i_tx_en = 1'b0;
   logic       i_dout_ready = 1'b0;
   logic [7:0] o_dout;
   logic       o_dout_valid;
   logic       o_dout_last;
   logic       o_frame_drop;
   logic [7:0] o_frame_cnt;

   tx_frame_packer #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_txd(i_txd), .i_tx_en(i_tx_en),
      .o_dout(o_dout), .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready),
      .o_dout_last(o_dout_last), .o_frame_drop(o_frame_drop), .o_frame_cnt(o_frame_cnt)
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;

   // Model: committed entries {data,last}, bytes of the open frame, and flags
   logic [8:0] out_q[$];
   logic [7:0] pend[$];
   bit         in_frame = 0;
   bit         discarding = 0;
   logic       exp_drop = 1'b0;
   logic [7:0] exp_cnt = 8'd0;

   logic [8:0] seen[$];
   int         drops_seen = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_dout = 8'd0;
   bit         tog = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      out_q.delete();
      pend.delete();
      in_frame   = 0;
      discarding = 0;
      exp_drop   = 1'b0;
      exp_cnt    = 8'd0;
      prev_stall = 0;
   endtask

   // One clock edge of the frame rules, evaluated on pre-edge occupancy
   task automatic model_edge(input logic en, input logic [7:0] d, input logic rdy);
      int free;
      bit pop;
      logic [7:0] x;
      free = DEPTH - (out_q.size() + pend.size());
      pop  = (out_q.size() != 0) && rdy;
      exp_drop = 1'b0;
      if (in_frame) begin
         if (en) begin
            if (pend.size() == MAX_LEN || free < 2) begin
               pend.delete();
               exp_drop = 1'b1;
               in_frame = 0;
               discarding = 1;
            end else pend.push_back(d);
         end else begin
            x = 8'd0;
            foreach (pend[i]) begin
               x = x ^ pend[i];
               out_q.push_back({pend[i], 1'b0});
            end
            out_q.push_back({x, 1'b1});
            pend.delete();
            in_frame = 0;
            exp_cnt  = exp_cnt + 8'd1;
         end
      end else if (discarding) begin
         if (!en) discarding = 0;
      end else if (en) begin
         if (free >= 2) begin
            pend.push_back(d);
            in_frame = 1;
         end else begin
            exp_drop = 1'b1;
            discarding = 1;
         end
      end
      if (pop) void'(out_q.pop_front());
   endtask

   task automatic check_outputs();
      chk("valid", o_dout_valid, out_q.size() != 0);
      if (out_q.size() != 0) begin
         chk("dout", o_dout, out_q[0][8:1]);
         chk("last", o_dout_last, out_q[0][0]);
      end else begin
         chk("dout_idle", o_dout, 0);
         chk("last_idle", o_dout_last, 0);
      end
      chk("frame_drop", o_frame_drop, exp_drop);
      chk("frame_cnt", o_frame_cnt, exp_cnt);
      if (prev_stall && o_dout_valid) chk("hold", o_dout, prev_dout);
   endtask

   function automatic logic pick_rdy(input int rmode);
      case (rmode)
         0: return 1'b0;
         1: return 1'b1;
         2: return tog;
         default: return logic'($urandom_range(0, 1));
      endcase
   endfunction

   // Called at a negedge: check, drive, clock, update model
   task automatic cyc(input logic en, input logic [7:0] d, input int rmode);
      logic rdy;
      rdy = pick_rdy(rmode);
      tog = ~tog;
      check_outputs();
      if (o_frame_drop) drops_seen++;
      i_tx_en = en;
      i_txd = d;
      i_dout_ready = rdy;
      if (o_dout_valid && rdy) seen.push_back({o_dout, o_dout_last});
      prev_stall = o_dout_valid && !rdy;
      prev_dout  = o_dout;
      @(posedge i_clk);
      model_edge(en, d, rdy);
      @(negedge i_clk);
   endtask

   task automatic send(input logic [7:0] f[$], input int rmode);
      foreach (f[i]) cyc(1'b1, f[i], rmode);
      cyc(1'b0, 8'd0, rmode);
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, rmode);
   endtask

   task automatic rand_frame(input int len, output logic [7:0] f[$]);
      f.delete();
      for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
   endtask

   logic [7:0] fr[$];
   logic [7:0] x4;

   initial begin
      // Reset state
      model_reset();
      @(negedge i_clk);
      chk("rst_valid", o_dout_valid, 0);
      chk("rst_dout", o_dout, 0);
      chk("rst_last", o_dout_last, 0);
      chk("rst_drop", o_frame_drop, 0);
      chk("rst_cnt", o_frame_cnt, 0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Three-byte frame with a free-running reader
      seen.delete();
      fr = '{8'd110, 8'd120, 8'd130};
      send(fr, 1);
      idle(6, 1);
      chk("t1_n", seen.size(), 4);
      if (seen.size() == 4) begin
         chk("t1_b0", seen[0], {8'd110, 1'b0});
         chk("t1_b1", seen[1], {8'd120, 1'b0});
         chk("t1_b2", seen[2], {8'd130, 1'b0});
         chk("t1_b3", seen[3], {8'd148, 1'b1});
      end
      chk("t1_cnt", o_frame_cnt, 1);

      // Single-byte frames separated by one idle cycle
      seen.delete();
      drops_seen = 0;
      fr = '{8'd100};
      send(fr, 1);
      fr = '{8'd120};
      send(fr, 1);
      idle(5, 1);
      chk("t2_n", seen.size(), 4);
      if (seen.size() == 4) begin
         chk("t2_b0", seen[0], {8'd100, 1'b0});
         chk("t2_b1", seen[1], {8'd100, 1'b1});
         chk("t2_b2", seen[2], {8'd120, 1'b0});
         chk("t2_b3", seen[3], {8'd120, 1'b1});
      end
      chk("t2_cnt", o_frame_cnt, 3);
      chk("t2_drops", drops_seen, 0);

      // Fill: second 8-byte frame runs out of room at byte 7
      drops_seen = 0;
      rand_frame(8, fr);
      send(fr, 0);
      rand_frame(8, fr);
      send(fr, 0);
      idle(2, 0);
      chk("t3_drops", drops_seen, 1);
      chk("t3_valid", o_dout_valid, 1);
      seen.delete();
      idle(12, 1);
      chk("t3_drained", seen.size(), 9);
      chk("t3_empty", o_dout_valid, 0);
      chk("t3_cnt", o_frame_cnt, 4);

      // Over-length frame dropped, next frame passes
      seen.delete();
      drops_seen = 0;
      rand_frame(9, fr);
      send(fr, 1);
      idle(3, 1);
      chk("t4_drops", drops_seen, 1);
      chk("t4_none", seen.size(), 0);
      chk("t4_cnt", o_frame_cnt, 4);
      rand_frame(2, fr);
      send(fr, 1);
      idle(5, 1);
      chk("t4_next", seen.size(), 3);
      chk("t4_cnt2", o_frame_cnt, 5);

      // Reset mid-frame with a committed frame queued
      fr = '{8'd1, 8'd2, 8'd3};
      send(fr, 0);
      cyc(1'b1, 8'd7, 0);
      cyc(1'b1, 8'd8, 0);
      i_rst = 1'b1;
      i_tx_en = 1'b0;
      #1;
      chk("t5_valid", o_dout_valid, 0);
      chk("t5_dout", o_dout, 0);
      chk("t5_last", o_dout_last, 0);
      chk("t5_cnt", o_frame_cnt, 0);
      chk("t5_drop", o_frame_drop, 0);
      model_reset();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      seen.delete();
      fr = '{8'd5, 8'd6};
      send(fr, 1);
      idle(4, 1);
      chk("t5_n", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("t5_b0", seen[0], {8'd5, 1'b0});
         chk("t5_b1", seen[1], {8'd6, 1'b0});
         chk("t5_b2", seen[2], {8'd3, 1'b1});
      end

      // Toggling backpressure during a four-byte frame
      seen.delete();
      rand_frame(4, fr);
      x4 = fr[0] ^ fr[1] ^ fr[2] ^ fr[3];
      send(fr, 2);
      idle(12, 2);
      chk("t6_n", seen.size(), 5);
      if (seen.size() == 5) begin
         for (int i = 0; i < 4; i++) chk("t6_b", seen[i], {fr[i], 1'b0});
         chk("t6_chk", seen[4], {x4, 1'b1});
      end

      // Random frames, gaps and backpressure
      for (int k = 0; k < 60; k++) begin
         rand_frame($urandom_range(1, MAX_LEN + 2), fr);
         send(fr, 3);
         idle($urandom_range(0, 2), 3);
      end
      idle(40, 1);
      chk("final_empty", o_dout_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tx_frame_packer.md
# tx_frame_packer

Downstream stage of the byte-stream `dut`: consumes its `txd`/`tx_en` output, groups each contiguous run of `tx_en`-high cycles into a frame, and appends an XOR checksum byte. Frames are buffered in an internal FIFO and released to the next stage over a valid/ready interface, with `dout_last` marking each frame's checksum byte. The read side sees only complete frames. A frame is dropped whole if it overflows the FIFO or exceeds `MAX_LEN`.

## Interface
- `DEPTH`, 16: FIFO entries, each 8 data bits plus a last flag; power of 2, ≥4.
- `MAX_LEN`, 8: maximum payload bytes per frame; 1 ≤ `MAX_LEN` ≤ `DEPTH`−1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `txd`  in  8  payload byte from the upstream `dut`.
- `tx_en`  in  1  `txd` is valid this cycle; contiguous high cycles form one frame.
- `dout`  out  8  head-of-FIFO byte; forced to 0 when `dout_valid`=0.
- `dout_valid`  out  1  committed data is available.
- `dout_ready`  in  1  downstream accepts `dout` this cycle.
- `dout_last`  out  1  head byte is a frame's checksum; 0 when `dout_valid`=0.
- `frame_drop`  out  1  one-cycle pulse per dropped frame.
- `frame_cnt`  out  8  committed frames modulo 256.

## Operation
- Pointers:
  - `wr_ptr` is speculative, `cm_ptr` is committed, `rd_ptr` is the read pointer.
  - Each is log2(DEPTH)+1 bits.
  - free = DEPTH − (`wr_ptr` − `rd_ptr`).
- Input FSM states: IDLE, COLLECT, DISCARD.
- IDLE:
  - If `tx_en` and free≥2: write {`txd`, last=0}, set chk=`txd`, len=1, go to COLLECT.
  - If `tx_en` and free<2: pulse drop, go to DISCARD.
- COLLECT, `tx_en`=1:
  - If len==`MAX_LEN` or free<2: roll `wr_ptr` back to `cm_ptr`, pulse drop, go to DISCARD.
  - Otherwise: write byte, chk^=`txd`, len++.
- COLLECT, `tx_en`=0 (frame end):
  - Write {chk, last=1}.
  - Set `cm_ptr` = `wr_ptr`+1 and increment `frame_cnt`.
  - Go to IDLE.
- DISCARD: ignore bytes; on `tx_en`=0 go to IDLE.
- Free-space rule: the free≥2 check guarantees the checksum slot is always available, so the checksum write never fails.
- Read side:
  - First-word fall-through.
  - `dout_valid` = (`rd_ptr` ≠ `cm_ptr`).
  - `dout`/`dout_last` = mem[`rd_ptr`].
  - On `dout_valid` & `dout_ready`, `rd_ptr`++.
- Concurrency: a read and a write may happen in the same cycle. free is computed from the registered pointers, so a read frees space only from the next cycle.
- Width rules: len saturates logic at `MAX_LEN`; `frame_cnt` wraps 255→0.

## Timing
- Reset (async, immediate):
  - Pointers 0, state IDLE, chk/len 0.
  - `dout`=0, `dout_valid`=0, `dout_last`=0, `frame_drop`=0, `frame_cnt`=0.
  - Memory contents are not reset.
- Reset mid-frame or with frames queued: everything is lost and the FIFO is empty after reset.
- Frame latency:
  - Last payload byte sampled at edge N.
  - `tx_en`=0 sampled at edge N+1: checksum written and committed.
  - `dout_valid` rises after edge N+1.
- `frame_drop` is registered: high for exactly the cycle after the edge at which the drop decision was made.
- Back-to-back frames: one `tx_en`-low cycle between frames is sufficient. That cycle writes the checksum, and a new frame may start on the next edge.
- A new frame can start in the same cycle that DISCARD returns to IDLE only on the following high `tx_en`.
- `dout` is stable while `dout_valid`=1 and `dout_ready`=0.

## Test plan
- Frame 110, 120, 130 (3 `tx_en` cycles, then low), `dout_ready`=1:
  - Output is 110, 120, 130, 148 (0x94).
  - `dout_last` is high only on 148.
  - `frame_cnt`=1.
- Single-byte frames 100 and 120, separated by one idle cycle:
  - Output is 100, 100(last), 120, 120(last).
  - `frame_cnt`=2; no `frame_drop`.
- `DEPTH`=16, `dout_ready`=0, 8-byte frame followed by an 8-byte frame:
  - First frame commits 9 entries.
  - Second frame drops at byte 7 (free=1); `frame_drop` pulses once.
  - After `dout_ready`=1, exactly 9 entries drain and `dout_valid` falls.
- 9-byte frame with `MAX_LEN`=8:
  - Dropped at byte 9 with a `frame_drop` pulse.
  - No output, and `frame_cnt` is unchanged.
  - A following 2-byte frame is output normally.
- `rst` asserted mid-frame after 2 bytes, with one committed frame still queued:
  - All outputs go to 0 immediately.
  - After release, a new frame 5, 6 outputs 5, 6, 3(last).
- Backpressure: toggle `dout_ready` every cycle during a 4-byte frame:
  - No byte is lost or duplicated.
  - `dout` holds its value while stalled.
